// File: rtl/rom_bist_pkg.sv
// Shared types and signature compaction for the ROM BIST engine.
// ROM_BIST_MISR_EN selects MISR compaction; otherwise an additive checksum is used.
package rom_bist_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SIG_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef ROM_BIST_MISR_EN
    function automatic logic [DEF_SIG_W-1:0] sig_next(input logic [DEF_SIG_W-1:0] sig,
                                                      input logic [DEF_DATA_W-1:0] data,
                                                      input logic [DEF_SIG_W-1:0] poly);
        sig_next = {sig[DEF_SIG_W-2:0], 1'b0}
                 ^ (sig[DEF_SIG_W-1] ? poly : {DEF_SIG_W{1'b0}})
                 ^ {{(DEF_SIG_W-DEF_DATA_W){1'b0}}, data};
    endfunction
`else
    // Plain modular sum; wraps silently at 2**DEF_SIG_W.
    function automatic logic [DEF_SIG_W-1:0] sig_next(input logic [DEF_SIG_W-1:0] sig,
                                                      input logic [DEF_DATA_W-1:0] data);
        sig_next = sig + {{(DEF_SIG_W-DEF_DATA_W){1'b0}}, data};
    endfunction
`endif

endpackage

// File: rtl/rom_bist_compactor.sv
// Signature register: loads SEED on Load, folds DataIn in via sig_next() on En.
// Compaction mode follows ROM_BIST_MISR_EN.
module rom_bist_compactor
    import rom_bist_pkg::*;
#(
    parameter int              SIG_W  = DEF_SIG_W,
    parameter int              DATA_W = DEF_DATA_W,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic              En,
    input  logic [DATA_W-1:0] DataIn,
    output logic [SIG_W-1:0]  Sig
);

`ifndef ROM_BIST_MISR_EN
    logic [SIG_W-1:0] poly_unused;
    assign poly_unused = POLY;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Sig <= SEED;
        end else if (Load) begin
            Sig <= SEED;
        end else if (En) begin
`ifdef ROM_BIST_MISR_EN
            Sig <= sig_next(Sig, DataIn, POLY);
`else
            Sig <= sig_next(Sig, DataIn);
`endif
        end
    end

endmodule

// File: rtl/ex_core_rom_bist.sv
// Memory-BIST engine for the 256x8 example-core ROM: address sweep, signature, compare.
// Compaction mode is selected by ROM_BIST_MISR_EN (see rom_bist_pkg).
module ex_core_rom_bist
    import rom_bist_pkg::*;
#(
    parameter int               ADDR_W = DEF_ADDR_W,
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] GOLDEN = 16'h7F80
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [SIG_W-1:0]  Signature,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t state;
    logic   load;
    logic   en;

    // Control handshake: Start is a one-cycle request accepted only in IDLE/DONE;
    // Abort is a level that wins over Start and forces IDLE from any state.
    assign load      = !Abort && Start && (state == IDLE || state == DONE);
    assign en        = !Abort && (state == RUN);
    assign dbg_state = state;

    rom_bist_compactor #(
        .SIG_W  (SIG_W),
        .DATA_W (DATA_W),
        .SEED   (SEED),
        .POLY   (POLY)
    ) u_compactor (
        .Clk    (Clk),
        .Rst    (Rst),
        .Load   (load),
        .En     (en),
        .DataIn (DataIn),
        .Sig    (Signature)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            Address <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Pass    <= 1'b0;
        end else if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state   <= RUN;
                        Address <= '0;
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                        Pass    <= 1'b0;
                    end
                end
                RUN: begin
                    // Address parks on the last location so CHECK sees a stable bus.
                    if (Address == LAST_ADDR) begin
                        state <= CHECK;
                    end else begin
                        Address <= Address + 1'b1;
                    end
                end
                CHECK: begin
                    Pass  <= (Signature == GOLDEN);
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_core_rom_bist.sv
// Bench for ex_core_rom_bist against a 256x8 ROM model (identity by default).
// Build with ROM_BIST_MISR_EN defined to exercise the MISR configuration.
module tb_ex_core_rom_bist;

    localparam logic [15:0] SEED_P = 16'h0000;
    localparam logic [15:0] POLY_P = 16'h1021;

`ifdef ROM_BIST_MISR_EN
    function automatic logic [15:0] f_ref(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] fb;
        fb = s[15] ? POLY_P : 16'h0000;
        f_ref = {s[14:0], 1'b0} ^ fb ^ {8'h00, d};
    endfunction

    function automatic logic [15:0] identity_golden();
        logic [15:0] s;
        s = SEED_P;
        for (int a = 0; a < 256; a++) s = f_ref(s, a[7:0]);
        return s;
    endfunction

    localparam logic [15:0] GOLDEN_P = identity_golden();
`else
    localparam logic [15:0] GOLDEN_P = 16'h7F80;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic        Abort;
    logic [7:0]  Address;
    logic [7:0]  DataIn;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [15:0] Signature;
    logic [1:0]  dbg_state;

    logic [7:0]  rom [256];
    bit          bit0_zero;
    bit          flip_en;
    logic [7:0]  flip_addr;

    int checks = 0;
    int errors = 0;

    ex_core_rom_bist #(
        .SEED   (SEED_P),
        .POLY   (POLY_P),
        .GOLDEN (GOLDEN_P)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Abort     (Abort),
        .Address   (Address),
        .DataIn    (DataIn),
        .Busy      (Busy),
        .Done      (Done),
        .Pass      (Pass),
        .Signature (Signature),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / ROM model ----------------
    always #5 Clk = ~Clk;

    always_comb begin
        DataIn = rom[Address];
        if (bit0_zero) DataIn[0] = 1'b0;
        if (flip_en && Address == flip_addr) DataIn[7] = ~DataIn[7];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] eff(input int a);
        logic [7:0] d;
        logic [7:0] ai;
        ai = 8'(a);
        d  = rom[ai];
        if (bit0_zero) d[0] = 1'b0;
        if (flip_en && ai == flip_addr) d[7] = ~d[7];
        return d;
    endfunction

    // Signature after the first 'upto' ROM words have been compacted.
    function automatic logic [15:0] model_sig(input int upto);
`ifdef ROM_BIST_MISR_EN
        logic [15:0] s;
        s = SEED_P;
        for (int a = 0; a < upto; a++) s = f_ref(s, eff(a));
        return s;
`else
        int unsigned total;
        logic [15:0] low;
        total = 0;
        for (int a = 0; a < upto; a++) total += eff(a);
        low = total[15:0];
        return SEED_P + low;
`endif
    endfunction

    task automatic load_identity();
        for (int a = 0; a < 256; a++) rom[a] = 8'(a);
        bit0_zero = 0;
        flip_en   = 0;
        flip_addr = 8'h00;
    endtask

    // ---------------- driver tasks ----------------
    // Full run from Start to Done; optional extra Start pulses while Busy at s1/s2.
    task automatic run_to_done(input string tag, input bit use_extra,
                               input logic [7:0] s1, input logic [7:0] s2);
        int n;
        logic [15:0] exp_sig;
        exp_sig = model_sig(256);
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        n = 1;
        while (!Done && n < 400) begin
            if (n <= 256) begin
                checks++;
                if (Address !== 8'(n - 1) || Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_sweep n=%0d addr=%h busy=%b expected addr=%h busy=1",
                             tag, n, Address, Busy, 8'(n - 1));
                end
            end
            Start = (use_extra && Busy && (Address == s1 || Address == s2));
            @(negedge Clk); n++;
        end
        Start = 1'b0;
        checks++;
        if (n !== 258) begin
            errors++;
            $display("FAIL %s_done_edge got=%0d expected=258", tag, n);
        end
        checks++;
        if (Signature !== exp_sig) begin
            errors++;
            $display("FAIL %s_signature got=%h expected=%h", tag, Signature, exp_sig);
        end
        checks++;
        if (Pass !== (exp_sig == GOLDEN_P) || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pass pass=%b busy=%b expected pass=%b busy=0",
                     tag, Pass, Busy, (exp_sig == GOLDEN_P));
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_level got=%b expected=1", tag, Done);
        end
    endtask

    // Start a run and stop on the negedge where Address == at (bounded).
    task automatic run_until(input logic [7:0] at, output bit ok);
        int n;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        n = 0;
        while (Address != at && n < 300) begin
            @(negedge Clk); n++;
        end
        ok = (Address == at);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_until addr=%h expected=%h", Address, at);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Address !== 8'h00 || Signature !== SEED_P || Busy !== 1'b0 || Done !== 1'b0 ||
            Pass !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values addr=%h sig=%h busy=%b done=%b pass=%b st=%0d expected 00 %h 0 0 0 0",
                     Address, Signature, Busy, Done, Pass, dbg_state, SEED_P);
        end
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_identity();
        load_identity();
        run_to_done("identity", 0, 8'h00, 8'h00);
`ifndef ROM_BIST_MISR_EN
        checks++;
        if (Signature !== 16'h7F80 || Pass !== 1'b1) begin
            errors++;
            $display("FAIL identity_literal sig=%h pass=%b expected 7f80 1", Signature, Pass);
        end
`endif
    endtask

    task automatic test_bit0_fault();
        load_identity();
        bit0_zero = 1;
        run_to_done("bit0", 0, 8'h00, 8'h00);
`ifndef ROM_BIST_MISR_EN
        checks++;
        if (Signature !== 16'h7F00 || Pass !== 1'b0) begin
            errors++;
            $display("FAIL bit0_literal sig=%h pass=%b expected 7f00 0", Signature, Pass);
        end
`endif
        bit0_zero = 0;
    endtask

    task automatic test_abort(input logic [7:0] at);
        bit ok;
        logic [15:0] exp_partial;
        load_identity();
        run_until(at, ok);
        if (ok) begin
            exp_partial = model_sig(int'(at));
            Abort = 1'b1;
            @(negedge Clk); Abort = 1'b0;
            checks++;
            if (dbg_state !== 2'd0 || Busy !== 1'b0 || Done !== 1'b0 || Pass !== 1'b0 ||
                Signature !== exp_partial) begin
                errors++;
                $display("FAIL abort_%h st=%0d busy=%b done=%b pass=%b sig=%h expected 0 0 0 0 %h",
                         at, dbg_state, Busy, Done, Pass, Signature, exp_partial);
            end
            repeat (3) @(negedge Clk);
            checks++;
            if (Busy !== 1'b0 || Signature !== exp_partial) begin
                errors++;
                $display("FAIL abort_hold busy=%b sig=%h expected 0 %h", Busy, Signature, exp_partial);
            end
        end
        run_to_done("after_abort", 0, 8'h00, 8'h00);
    endtask

    task automatic test_start_while_busy();
        load_identity();
        run_to_done("start_busy", 1, 8'h10, 8'hFF);
        run_to_done("start_busy_rand", 1, 8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)));
    endtask

    task automatic test_abort_in_done_and_priority();
        load_identity();
        run_to_done("pre_abort_done", 0, 8'h00, 8'h00);
        @(negedge Clk); Abort = 1'b1; Start = 1'b1;
        @(negedge Clk); Abort = 1'b0; Start = 1'b0;
        checks++;
        if (dbg_state !== 2'd0 || Done !== 1'b0 || Pass !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_over_start st=%0d done=%b pass=%b busy=%b expected 0 0 0 0",
                     dbg_state, Done, Pass, Busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        load_identity();
        run_until(8'h80, ok);
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (Address !== 8'h00 || Signature !== SEED_P || Busy !== 1'b0 || Done !== 1'b0 ||
            Pass !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_run addr=%h sig=%h busy=%b done=%b pass=%b st=%0d",
                     Address, Signature, Busy, Done, Pass, dbg_state);
        end
        #1 Rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0 || Address !== 8'h00) begin
                errors++;
                $display("FAIL reset_quiet i=%0d done=%b busy=%b addr=%h expected 0 0 00",
                         i, Done, Busy, Address);
            end
        end
        run_to_done("after_reset", 0, 8'h00, 8'h00);
    endtask

    task automatic test_random_rom();
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
            bit0_zero = 0; flip_en = 0;
            run_to_done("random_rom", 1, 8'($urandom), 8'($urandom));
        end
        load_identity();
    endtask

    task automatic test_flip_a5();
        load_identity();
        flip_en = 1; flip_addr = 8'hA5;
        run_to_done("flip_a5", 0, 8'h00, 8'h00);
        checks++;
        if (Pass !== 1'b0) begin
            errors++;
            $display("FAIL flip_a5_pass got=%b expected=0", Pass);
        end
        flip_en = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0;
        load_identity();
        test_reset();
        test_identity();
        test_bit0_fault();
        test_abort(8'h40);
        test_abort(8'($urandom_range(1, 254)));
        test_start_while_busy();
        test_abort_in_done_and_priority();
        test_reset_mid_run();
        test_random_rom();
        test_flip_a5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
